coin_acceptor: RTL and testbench

Front-end stage that sits directly upstream of the vending FSM. It converts three raw, bouncy, asynchronous coin-sensor lines into clean single-cycle one-hot pulses on nickel/dime/quarter. Coins that arrive together or back-to-back are buffered and released one per pulse, with a guaranteed idle gap, so the downstream FSM sees at most one coin per cycle and never misses one.

---
 rtl/vending_pkg.sv | 19 +
 rtl/coin_debounce.sv | 52 +++++
 rtl/coin_acceptor.sv | 160 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types for the coin front-end and the vending FSM.
package vending_pkg;

  // 2-bit coin codes as stored in the coin-event queue.
  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_e;

  // Output sequencer states.
  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_EMIT,
    ACC_GAP
  } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on every 0->1 change of the debounced level.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             level;

  // Bring the asynchronous sensor line into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
    end
  end

  // Flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count. rise_o marks an upward flip.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      level  <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        level  <= sync_p1;
        rise_o <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front-end: debounces three sensor lines, queues coin events and
// releases them as single-cycle one-hot pulses separated by an idle gap.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        nickel_raw_i,
  input  logic                        dime_raw_i,
  input  logic                        quarter_raw_i,
  input  logic                        accept_en_i,
  output logic                        nickel_o,
  output logic                        dime_o,
  output logic                        quarter_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        drop_o,
  output logic [7:0]                  drop_cnt_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FREE_W = CNT_W + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [2:0] coin_onehot(input coin_e c);
    case (c)
      COIN_NICKEL:  return 3'b001;
      COIN_DIME:    return 3'b010;
      COIN_QUARTER: return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

  logic [2:0]        rise;
  coin_e             ev [3];
  logic [1:0]        ev_n;
  logic [1:0]        push_n;
  logic [1:0]        drop_n;
  logic [FREE_W-1:0] free;
  coin_e             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              take;
  acc_state_e        state;
  acc_state_e        state_nx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_cnt_nx;
  logic [2:0]        coin_q;
  logic [2:0]        coin_nx;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_nickel (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(nickel_raw_i), .rise_o(rise[0]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dime (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(dime_raw_i), .rise_o(rise[1]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_quarter (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(quarter_raw_i), .rise_o(rise[2]));

  // Pack this cycle's events in nickel/dime/quarter order and keep as many
  // as fit; a same-cycle pop frees one slot, the tail of the list is dropped.
  always_comb begin
    ev[0] = COIN_NONE;
    ev[1] = COIN_NONE;
    ev[2] = COIN_NONE;
    ev_n  = 2'd0;
    if (rise[0]) begin ev[ev_n] = COIN_NICKEL;  ev_n = ev_n + 2'd1; end
    if (rise[1]) begin ev[ev_n] = COIN_DIME;    ev_n = ev_n + 2'd1; end
    if (rise[2]) begin ev[ev_n] = COIN_QUARTER; ev_n = ev_n + 2'd1; end
    free = FREE_W'(FIFO_DEPTH) - FREE_W'(count) + FREE_W'(pop);
    if (FREE_W'(ev_n) > free) push_n = free[1:0];
    else                      push_n = ev_n;
    drop_n = ev_n - push_n;
  end

  // Queue pointers, occupancy and drop statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_o     <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_n);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count + CNT_W'(push_n) - CNT_W'(pop);
      drop_o     <= (drop_n != 2'd0);
      drop_cnt_o <= sat_add(drop_cnt_o, drop_n);
    end
  end

  // Queue storage; contents are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < 3; j++) begin
      if (j < int'(push_n)) mem[wr_ptr + PTR_W'(j)] <= ev[j];
    end
  end

  // Sequencer next state: a pop can start from IDLE or on the last GAP
  // cycle, so back-to-back coins come out every GAP_CYCLES+1 cycles.
  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    coin_nx    = 3'b000;
    pop        = 1'b0;
    take       = 1'b0;
    unique case (state)
      ACC_IDLE: take = 1'b1;
      ACC_EMIT: begin
        state_nx   = ACC_GAP;
        gap_cnt_nx = '0;
      end
      ACC_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = ACC_IDLE;
          take     = 1'b1;
        end else begin
          gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nx = ACC_IDLE;
    endcase
    if (take && accept_en_i && (count != '0)) begin
      pop      = 1'b1;
      state_nx = ACC_EMIT;
      coin_nx  = coin_onehot(mem[rd_ptr]);
    end
  end

  // Sequencer state and registered coin pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ACC_IDLE;
      gap_cnt <= '0;
      coin_q  <= 3'b000;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_cnt_nx;
      coin_q  <= coin_nx;
    end
  end

  assign nickel_o     = coin_q[0];
  assign dime_o       = coin_q[1];
  assign quarter_o    = coin_q[2];
  assign fifo_count_o = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_coin_acceptor;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       n_raw = 1'b0, d_raw = 1'b0, q_raw = 1'b0, acc = 1'b0;
  logic       nickel_o, dime_o, quarter_o, drop_o;
  logic [2:0] fifo_count_o;
  logic [7:0] drop_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .nickel_raw_i(n_raw), .dime_raw_i(d_raw), .quarter_raw_i(q_raw),
    .accept_en_i(acc),
    .nickel_o(nickel_o), .dime_o(dime_o), .quarter_o(quarter_o),
    .fifo_count_o(fifo_count_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o));

  // Behavioural model: edges counted since reset release.
  int k;
  bit hist [3][4096];
  int lvl [3];
  int q[$];
  int pend[$];
  int next_ok;
  int m_drop_cnt;
  int exp_coin;
  int exp_drop;

  // Observation bookkeeping for the directed checks.
  int pulse_cnt [3];
  int first_edge [3];
  int drop_pulses;

  // Value seen by the debouncer at edge j: raw sampled two edges earlier.
  function automatic int synced(int c, int j);
    return (j >= 3) ? int'(hist[c][j-3]) : 0;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < 3; c++) lvl[c] = 0;
    q.delete();
    pend.delete();
    next_ok    = 0;
    m_drop_cnt = 0;
  endtask

  task automatic model_edge(input bit rn, input bit rd, input bit rq, input bit a);
    int nd;
    bit flip;
    k++;
    hist[0][k-1] = rn;
    hist[1][k-1] = rd;
    hist[2][k-1] = rq;
    exp_coin = 0;
    if (k >= next_ok && q.size() > 0 && a) begin
      exp_coin = q.pop_front();
      next_ok  = k + 1 + GAP;
    end
    nd = 0;
    foreach (pend[i]) begin
      if (q.size() < DEPTH) q.push_back(pend[i]);
      else nd++;
    end
    pend.delete();
    exp_drop   = (nd > 0) ? 1 : 0;
    m_drop_cnt = (m_drop_cnt + nd > 255) ? 255 : m_drop_cnt + nd;
    for (int c = 0; c < 3; c++) begin
      flip = 1'b1;
      for (int j = k - D + 1; j <= k; j++)
        if (synced(c, j) == lvl[c]) flip = 1'b0;
      if (flip) begin
        lvl[c] = 1 - lvl[c];
        if (lvl[c] == 1) pend.push_back(c + 1);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < 3; c++) begin
      pulse_cnt[c]  = 0;
      first_edge[c] = -1;
    end
    drop_pulses = 0;
  endtask

  task automatic record(input int c, input logic v);
    if (v) begin
      pulse_cnt[c]++;
      if (first_edge[c] < 0) first_edge[c] = k;
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic cyc(input bit rn, input bit rd, input bit rq, input bit a);
    @(negedge clk_i);
    n_raw = rn; d_raw = rd; q_raw = rq; acc = a;
    @(posedge clk_i);
    model_edge(rn, rd, rq, a);
    #1;
    check("nickel_o",     nickel_o,     exp_coin == 1);
    check("dime_o",       dime_o,       exp_coin == 2);
    check("quarter_o",    quarter_o,    exp_coin == 3);
    check("fifo_count_o", fifo_count_o, q.size());
    check("drop_o",       drop_o,       exp_drop);
    check("drop_cnt_o",   drop_cnt_o,   m_drop_cnt);
    record(0, nickel_o);
    record(1, dime_o);
    record(2, quarter_o);
    if (drop_o) drop_pulses++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_nickel"},  nickel_o,     0);
    check({tag, "_dime"},    dime_o,       0);
    check({tag, "_quarter"}, quarter_o,    0);
    check({tag, "_count"},   fifo_count_o, 0);
    check({tag, "_drop"},    drop_o,       0);
    check({tag, "_dropcnt"}, drop_cnt_o,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit rl [3];
    bit ra;
    bit rv [3];

    // Reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // Clean nickel: pulse once, after edge 8
    clear_obs();
    repeat (12) cyc(1, 0, 0, 1);
    repeat (10) cyc(0, 0, 0, 1);
    check("t1_nickel_pulses", pulse_cnt[0], 1);
    check("t1_nickel_edge",   first_edge[0], 8);
    check("t1_other_pulses",  pulse_cnt[1] + pulse_cnt[2], 0);

    // Bouncing dime gives one pulse, 3-cycle quarter glitch gives none
    clear_obs();
    cyc(0, 1, 0, 1); cyc(0, 0, 0, 1); cyc(0, 1, 0, 1); cyc(0, 0, 0, 1);
    repeat (10) cyc(0, 1, 0, 1);
    repeat (10) cyc(0, 0, 0, 1);
    check("t2_dime_pulses", pulse_cnt[1], 1);
    repeat (3)  cyc(0, 0, 1, 1);
    repeat (10) cyc(0, 0, 0, 1);
    check("t2_quarter_pulses", pulse_cnt[2], 0);

    // Simultaneous coins leave at t, t+2, t+4
    clear_obs();
    repeat (12) cyc(1, 1, 1, 1);
    repeat (12) cyc(0, 0, 0, 1);
    check("t3_dime_spacing",    first_edge[1] - first_edge[0], 2);
    check("t3_quarter_spacing", first_edge[2] - first_edge[0], 4);
    check("t3_pulse_total",     pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 3);

    // Stall with three queued coins, then drain in order
    clear_obs();
    repeat (10) cyc(1, 1, 1, 0);
    repeat (8)  cyc(0, 0, 0, 0);
    check("t4_count_stalled", fifo_count_o, 3);
    check("t4_no_pulses",     pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
    repeat (10) cyc(0, 0, 0, 1);
    check("t4_count_drained", fifo_count_o, 0);
    check("t4_order", (first_edge[0] < first_edge[1]) && (first_edge[1] < first_edge[2]), 1);

    // Overflow: fill four slots, then two more coins are both dropped
    clear_obs();
    repeat (8) cyc(1, 1, 1, 0);
    repeat (8) cyc(0, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    check("t5_count_full", fifo_count_o, 4);
    repeat (8) cyc(0, 1, 1, 0);
    repeat (8) cyc(0, 0, 0, 0);
    check("t5_count_still_full", fifo_count_o, 4);
    check("t5_drop_cnt",         drop_cnt_o, 2);
    check("t5_drop_pulses",      drop_pulses, 1);
    repeat (14) cyc(0, 0, 0, 1);
    check("t5_drained", fifo_count_o, 0);

    // Reset during a quarter pulse clears outputs without a clock edge
    clear_obs();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 1'b0, (i < 8), 1'b1);
      if (quarter_o) found = 1'b1;
    end
    check("t6_quarter_seen", found, 1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_async_quarter", quarter_o,    0);
    check("t6_async_count",   fifo_count_o, 0);
    n_raw = 1'b0; d_raw = 1'b0; q_raw = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    clear_obs();
    repeat (20) cyc(0, 0, 0, 1);
    check("t6_no_pulses_after", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);

    // Random sensor traffic with glitches and accept stalls
    for (int c = 0; c < 3; c++) rl[c] = 1'b0;
    ra = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(11) == 0) rl[c] = ~rl[c];
        rv[c] = ($urandom_range(29) == 0) ? ~rl[c] : rl[c];
      end
      if ($urandom_range(15) == 0) ra = ~ra;
      cyc(rv[0], rv[1], rv[2], ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
